// File: rtl/muldiv_ctrl_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
// The pipeline side drives the operation request; the unit returns stall and HI/LO results.
interface muldiv_ctrl_if;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_o;
  logic        result_valid;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output op_valid, op_type, src_a, src_b, flush,
    input  stall_o, result_valid, hi_o, lo_o
  );

  modport slave (
    input  op_valid, op_type, src_a, src_b, flush,
    output stall_o, result_valid, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// MIPS-style HI/LO multiply/divide controller: single-cycle multiply, 32-cycle restoring divide.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips straight to DONE with lo=all-ones, hi=dividend.
module muldiv_ctrl (
  input  logic          clk,
  input  logic          resetn,
  muldiv_ctrl_if.slave  bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            uns_q, uns_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    rem_q, rem_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  logic            accept;
  logic            uns_in, a_neg_in, b_neg_in;
  logic            fast_zero;
  logic [W-1:0]    mag_a, mag_b;
  logic [2*W-1:0]  ext_a, ext_b, product;
  logic [W:0]      trial, diff;
  logic            ge;
  logic [W-1:0]    rem_nxt, quo_nxt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    uns_d   = uns_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    accept   = bus.op_valid & ~bus.flush;
    uns_in   = bus.op_type[0];
    a_neg_in = ~uns_in & bus.src_a[W-1];
    b_neg_in = ~uns_in & bus.src_b[W-1];
    mag_a    = a_neg_in ? (~bus.src_a + W'(1)) : bus.src_a;
    mag_b    = b_neg_in ? (~bus.src_b + W'(1)) : bus.src_b;
    fast_zero = 1'b0;
`ifdef DIV_ZERO_FAST_EN
    fast_zero = (bus.src_b == '0);
`endif

    // Sign-extended 64-bit operands give the signed product modulo 2^64.
    ext_a   = {{W{~uns_q & a_q[W-1]}}, a_q};
    ext_b   = {{W{~uns_q & b_q[W-1]}}, b_q};
    product = ext_a * ext_b;

    // One restoring step: a_q shifts the dividend out and the quotient in.
    trial   = {rem_q, a_q[W-1]};
    diff    = trial - {1'b0, b_q};
    ge      = (trial >= {1'b0, b_q});
    rem_nxt = ge ? diff[W-1:0] : trial[W-1:0];
    quo_nxt = {a_q[W-2:0], ge};

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          uns_d = uns_in;
          if (bus.op_type[1]) begin
            if (fast_zero) begin
              state_d = S_DONE;
              hi_d    = bus.src_a;
              lo_d    = '1;
            end else begin
              state_d = S_DIV;
              cnt_d   = '0;
              a_d     = mag_a;
              b_d     = mag_b;
              rem_d   = '0;
              qneg_d  = a_neg_in ^ b_neg_in;
              rneg_d  = a_neg_in;
            end
          end else begin
            state_d = S_MUL;
            a_d     = bus.src_a;
            b_d     = bus.src_b;
          end
        end
      end
      S_MUL: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          hi_d    = product[2*W-1:W];
          lo_d    = product[W-1:0];
        end
      end
      S_DIV: begin
        if (bus.flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          a_d   = quo_nxt;
          rem_d = rem_nxt;
          cnt_d = CW'(cnt_q + CW'(1));
          if (cnt_q == CW'(W-1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
            hi_d    = rneg_q ? (~rem_nxt + W'(1)) : rem_nxt;
            lo_d    = qneg_q ? (~quo_nxt + W'(1)) : quo_nxt;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      uns_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      uns_q   <= uns_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Stall and result strobe react to the same-cycle request and flush.
  assign bus.stall_o      = resetn & ((state_q == S_MUL) | (state_q == S_DIV) |
                                      ((state_q == S_IDLE) & accept));
  assign bus.result_valid = (state_q == S_DONE) & ~bus.flush;
  assign bus.hi_o         = hi_q;
  assign bus.lo_o         = lo_q;

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port op_valid, input, 1, a decoded MULT/MULTU/DIV/DIVU is present in the execute stage.
REQ-004 SHALL have port op_type, input, 2, with encoding 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port src_a, input, 32, the rs operand or dividend.
REQ-006 SHALL have port src_b, input, 32, the rt operand or divisor.
REQ-007 SHALL have port flush, input, 1, an exception or ERET flush that kills the in-flight operation.
REQ-008 SHALL have port stall_o, output, 1, which freezes the pipeline at and before the execute stage.
REQ-009 SHALL have port result_valid, output, 1, a one-cycle pulse that writes the HI/LO register file.
REQ-010 SHALL have ports hi_o and lo_o, output, 32 each, carrying the HI and LO results.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV and DONE.
REQ-012 SHALL accept an operation in IDLE when op_valid=1 and flush=0, registering op_type, src_a and src_b.
- MULT/MULTU SHALL go to MUL.
- DIV/DIVU SHALL go to DIV with iteration counter=0.
REQ-013 SHALL spend exactly 1 cycle in MUL, computing the 64-bit signed or unsigned product, then go to DONE.
REQ-014 SHALL run DIV as restoring shift-subtract on the operand magnitudes, one quotient bit per cycle, and go to DONE when the counter reaches 31 (32 cycles).
REQ-015 SHALL apply signed-divide fixup: quotient negated when the operand signs differ; remainder takes the dividend's sign; results are 2's complement, truncating toward zero.
REQ-016 SHALL set latency from the acceptance cycle T: MULT/MULTU result_valid at T+2; DIV/DIVU result_valid at T+33.
REQ-017 SHALL drive stall_o = (state==MUL or state==DIV) or (state==IDLE and op_valid and not flush); stall_o=0 in DONE.
REQ-018 SHALL drive result_valid = (state==DONE and not flush).
- hi_o/lo_o SHALL update on the edge entering DONE.
- hi_o = product[63:32] or remainder; lo_o = product[31:0] or quotient.
REQ-019 SHALL go from DONE to IDLE unconditionally and ignore op_valid in DONE, so a held instruction is never re-issued.
REQ-020 SHALL, on flush in MUL or DIV, go to IDLE next cycle, with no result_valid and hi_o/lo_o unchanged.
REQ-021 SHALL, on flush in DONE, suppress result_valid; hi_o/lo_o may already hold the new value, but the HI/LO file is not written.
REQ-022 SHALL hold hi_o/lo_o from the last completion until the next completion.

Reset
REQ-023 SHALL, while resetn=0, force state=IDLE, counter=0, hi_o=0, lo_o=0, result_valid=0 and stall_o=0.
REQ-024 SHALL abandon any in-flight operation on reset asserted mid-operation, with no result produced after release.

Configuration
REQ-025 SHALL compile the fast divide-by-zero path only when macro DIV_ZERO_FAST_EN is defined: DIV/DIVU with src_b==0 goes IDLE->DONE directly, result_valid at T+1, lo_o=32'hFFFFFFFF, hi_o=src_a, stall_o high only in cycle T.
REQ-026 SHALL, without DIV_ZERO_FAST_EN, run a zero divisor through the full 32 iterations (T+33) with no special check; the result is architecturally undefined.

Verification
REQ-027 SHALL cover MULTU src_a=32'hFFFFFFFF, src_b=2 -> result_valid at T+2, hi_o=1, lo_o=32'hFFFFFFFE.
REQ-028 SHALL cover MULT src_a=-3, src_b=5 -> hi_o=32'hFFFFFFFF, lo_o=32'hFFFFFFF1.
REQ-029 SHALL cover DIVU 100/7 -> stall_o high T..T+32 and low at T+33; result_valid at T+33 with lo_o=14, hi_o=2.
REQ-030 SHALL cover DIV -7/2 -> lo_o=32'hFFFFFFFD, hi_o=32'hFFFFFFFF.
REQ-031 SHALL cover flush at T+10 during DIV (prior hi_o=lo_o=5) -> IDLE at T+11, no result_valid, hi_o=lo_o=5, stall_o low once op_valid drops.
REQ-032 SHALL cover DIVU 9/0 with DIV_ZERO_FAST_EN -> result_valid at T+1, lo_o=32'hFFFFFFFF, hi_o=9; and op_valid held high through DONE -> exactly one result_valid pulse.
